aes_decrypt_iter: RTL and testbench

Iterative AES-128 decryption engine, the inverse counterpart of the encryption round datapath. It accepts a 128-bit cipher key and one ciphertext block through a valid/ready handshake. It rolls the key schedule forward to the final round key, then runs ten inverse rounds while unrolling the key schedule backward one round key per cycle. It emits the plaintext through a valid/ready output handshake and sits beside the encryption path as the receive-side block transform.

---
 rtl/aes_decrypt_iter.sv | 251 +++++++++++++++++++++++++
 tb/tb_aes_decrypt_iter.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/aes_decrypt_iter.sv
// Iterative AES-128 decryption engine: one inverse round per cycle, with the
// key schedule rolled forward to k10 and then unrolled backward per round.
// Ports: clk, reset (sync, active-high); in_valid/in_ready with key/data;
//        out_valid/out_ready with r_out (plaintext, same byte order as data).
// Byte 15 of key/data/r_out is FIPS-197 byte 0; state is column-major.
// Optional macro AES_DEC_KEY_CACHE_EN: cache the last key/k10 pair so a
// repeated key skips the forward key expansion.

module aes_decrypt_iter (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [15:0][7:0] key,
   input  logic [15:0][7:0] data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [15:0][7:0] r_out
);

   typedef logic [15:0][7:0] blk_t;
   typedef enum logic [1:0] {IDLE, KEYGEN, ROUND, DONE} state_e;

   function automatic logic [7:0] xt(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a,
                                       input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = '0;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = xt(x);
      end
      return p;
   endfunction

   // Multiplicative inverse as a^254; maps 0 to 0 as the S-box requires.
   function automatic logic [7:0] ginv(input logic [7:0] a);
      logic [7:0] x2, x3, x6, x12, x15, x30, x60, x120, x240, x252;
      x2   = gmul(a, a);
      x3   = gmul(x2, a);
      x6   = gmul(x3, x3);
      x12  = gmul(x6, x6);
      x15  = gmul(x12, x3);
      x30  = gmul(x15, x15);
      x60  = gmul(x30, x30);
      x120 = gmul(x60, x60);
      x240 = gmul(x120, x120);
      x252 = gmul(x240, x12);
      return gmul(x252, x2);
   endfunction

   function automatic logic [7:0] sbox(input logic [7:0] a);
      logic [7:0] b;
      b = ginv(a);
      return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]}
               ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
   endfunction

   // Inverse affine map first, then field inversion.
   function automatic logic [7:0] inv_sbox(input logic [7:0] a);
      logic [7:0] y;
      y = {a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05;
      return ginv(y);
   endfunction

   function automatic logic [31:0] sub_rot(input logic [31:0] w);
      return {sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0]), sbox(w[31:24])};
   endfunction

   function automatic logic [7:0] rcon(input logic [3:0] rc);
      logic [7:0] r;
      case (rc)
         4'd1:    r = 8'h01;
         4'd2:    r = 8'h02;
         4'd3:    r = 8'h04;
         4'd4:    r = 8'h08;
         4'd5:    r = 8'h10;
         4'd6:    r = 8'h20;
         4'd7:    r = 8'h40;
         4'd8:    r = 8'h80;
         4'd9:    r = 8'h1b;
         4'd10:   r = 8'h36;
         default: r = 8'h00;
      endcase
      return r;
   endfunction

   function automatic logic [127:0] key_fwd(input logic [127:0] k,
                                            input logic [7:0]   rcv);
      logic [31:0] n0, n1, n2, n3;
      n0 = k[127:96] ^ sub_rot(k[31:0]) ^ {rcv, 24'h0};
      n1 = k[95:64] ^ n0;
      n2 = k[63:32] ^ n1;
      n3 = k[31:0] ^ n2;
      return {n0, n1, n2, n3};
   endfunction

   // Undo one expansion step: recover w3..w1 first, then w0 from old w3.
   function automatic logic [127:0] key_inv(input logic [127:0] k,
                                            input logic [7:0]   rcv);
      logic [31:0] p0, p1, p2, p3;
      p3 = k[31:0] ^ k[63:32];
      p2 = k[63:32] ^ k[95:64];
      p1 = k[95:64] ^ k[127:96];
      p0 = k[127:96] ^ sub_rot(p3) ^ {rcv, 24'h0};
      return {p0, p1, p2, p3};
   endfunction

   // s'[r][c] = InvSbox(s[r][(c-r) mod 4]); FIPS index r+4c is byte 15-(r+4c).
   function automatic blk_t inv_shift_sub(input blk_t s);
      blk_t o;
      for (int r = 0; r < 4; r++) begin
         for (int c = 0; c < 4; c++) begin
            o[15-(r+4*c)] = inv_sbox(s[15-(r+4*((c-r+4)%4))]);
         end
      end
      return o;
   endfunction

   function automatic blk_t inv_mix(input blk_t s);
      blk_t o;
      logic [7:0] a0, a1, a2, a3;
      for (int c = 0; c < 4; c++) begin
         a0 = s[15-4*c];
         a1 = s[14-4*c];
         a2 = s[13-4*c];
         a3 = s[12-4*c];
         o[15-4*c] = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b)
                   ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
         o[14-4*c] = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e)
                   ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
         o[13-4*c] = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09)
                   ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
         o[12-4*c] = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d)
                   ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
      end
      return o;
   endfunction

   state_e       state_q, state_d;
   blk_t         st_q, st_d;
   logic [127:0] key_q, key_d;
   logic [3:0]   rc_q, rc_d;
   logic [127:0] k_fwd, k_prev;
   blk_t         t_w;

`ifdef AES_DEC_KEY_CACHE_EN
   logic [127:0] ckey_q, ckey_d;
   logic [127:0] ck10_q, ck10_d;
   logic         cvalid_q, cvalid_d;
`endif

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign r_out     = st_q;

   always_comb begin
      state_d = state_q;
      st_d    = st_q;
      key_d   = key_q;
      rc_d    = rc_q;
      k_fwd   = key_fwd(key_q, rcon(rc_q));
      k_prev  = key_inv(key_q, rcon(rc_q));
      t_w     = inv_shift_sub(st_q) ^ k_prev;
`ifdef AES_DEC_KEY_CACHE_EN
      ckey_d   = ckey_q;
      ck10_d   = ck10_q;
      cvalid_d = cvalid_q;
`endif
      unique case (state_q)
         IDLE: begin
            if (in_valid) begin
`ifdef AES_DEC_KEY_CACHE_EN
               if (cvalid_q && (key == ckey_q)) begin
                  key_d   = ck10_q;
                  st_d    = data ^ ck10_q;
                  rc_d    = 4'd10;
                  state_d = ROUND;
               end else begin
                  // Remember the original key; k10 is paired at KEYGEN end.
                  ckey_d   = key;
                  cvalid_d = 1'b0;
                  key_d    = key;
                  st_d     = data;
                  rc_d     = 4'd1;
                  state_d  = KEYGEN;
               end
`else
               key_d   = key;
               st_d    = data;
               rc_d    = 4'd1;
               state_d = KEYGEN;
`endif
            end
         end
         KEYGEN: begin
            key_d = k_fwd;
            rc_d  = rc_q + 4'd1;
            if (rc_q == 4'd10) begin
               st_d    = st_q ^ k_fwd;
               rc_d    = 4'd10;
               state_d = ROUND;
`ifdef AES_DEC_KEY_CACHE_EN
               ck10_d   = k_fwd;
               cvalid_d = 1'b1;
`endif
            end
         end
         ROUND: begin
            key_d = k_prev;
            rc_d  = rc_q - 4'd1;
            st_d  = (rc_q > 4'd1) ? inv_mix(t_w) : t_w;
            if (rc_q == 4'd1) state_d = DONE;
         end
         DONE: begin
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         st_q    <= '0;
         key_q   <= '0;
         rc_q    <= '0;
`ifdef AES_DEC_KEY_CACHE_EN
         ckey_q   <= '0;
         ck10_q   <= '0;
         cvalid_q <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         st_q    <= st_d;
         key_q   <= key_d;
         rc_q    <= rc_d;
`ifdef AES_DEC_KEY_CACHE_EN
         ckey_q   <= ckey_d;
         ck10_q   <= ck10_d;
         cvalid_q <= cvalid_d;
`endif
      end
   end

endmodule

// File: tb/tb_aes_decrypt_iter.sv
// Bench for aes_decrypt_iter: known-answer vectors, latency, backpressure,
// mid-round reset and streaming throughput.

module tb_aes_decrypt_iter;

   logic clk = 1'b0;
   logic reset, in_valid, in_ready, out_valid, out_ready;
   logic [15:0][7:0] key, data, r_out;

   int n_cmp = 0;
   int n_err = 0;
   int cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   aes_decrypt_iter dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .key       (key),
      .data      (data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .r_out     (r_out)
   );

   typedef struct packed {
      logic [127:0] k;
      logic [127:0] ct;
      logic [127:0] pt;
   } vec_t;

   vec_t v [6];

   // Reference model of the key cache: which key would hit.
   bit m_valid = 1'b0;
   logic [127:0] m_key = '0;

   function automatic int exp_lat(input logic [127:0] k);
`ifdef AES_DEC_KEY_CACHE_EN
      return (m_valid && k == m_key) ? 10 : 20;
`else
      return 20;
`endif
   endfunction

   task automatic chk(input string nm, input logic [255:0] act,
                      input logic [255:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic accept(input logic [127:0] k, input logic [127:0] d,
                         input bit keep, output int acc, output bit ok);
      ok = 1'b0;
      acc = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (in_ready) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) begin
         chk("accept_timeout", 256'd0, 256'd1);
         return;
      end
      key = k;
      data = d;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      acc = cyc;
      if (!keep) in_valid = 1'b0;
   endtask

   task automatic wait_out(output int c, output bit ok);
      ok = 1'b0;
      c = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (out_valid) begin
            ok = 1'b1;
            c = cyc;
            return;
         end
      end
      chk("out_timeout", 256'd0, 256'd1);
   endtask

   task automatic run_vec(input int idx);
      int acc, c, el;
      bit ok;
      el = exp_lat(v[idx].k);
      accept(v[idx].k, v[idx].ct, 1'b0, acc, ok);
      if (!ok) return;
      wait_out(c, ok);
      if (!ok) return;
      chk($sformatf("pt_%0d", idx), r_out, v[idx].pt);
      chk($sformatf("lat_%0d", idx), c - acc, el);
      m_valid = 1'b1;
      m_key = v[idx].k;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      @(negedge clk);
      chk($sformatf("idle_%0d", idx), {in_ready, out_valid}, 2'b10);
   endtask

   initial begin
      int acc, c, el, prev_acc, prev_lat;
      bit ok, seen;

      v[0] = '{128'h000102030405060708090a0b0c0d0e0f,
               128'h69c4e0d86a7b0430d8cdb78070b4c55a,
               128'h00112233445566778899aabbccddeeff};
      v[1] = v[0];
      v[2] = '{128'h2b7e151628aed2a6abf7158809cf4f3c,
               128'h3925841d02dc09fbdc118597196a0b32,
               128'h3243f6a8885a308d313198a2e0370734};
      v[3] = '{128'h2b7e151628aed2a6abf7158809cf4f3c,
               128'h3ad77bb40d7a3660a89ecaf32466ef97,
               128'h6bc1bee22e409f96e93d7e117393172a};
      v[4] = '{128'h0,
               128'h66e94bd4ef8a2c3b884cfa59ca342b2e,
               128'h0};
      v[5] = '{128'h2b7e151628aed2a6abf7158809cf4f3c,
               128'hf5d3d58503b9699de785895a96fdbaaf,
               128'hae2d8a571e03ac9c9eb76fac45af8e51};

      // Reset held together with in_valid must not accept.
      reset = 1'b1;
      in_valid = 1'b1;
      out_ready = 1'b0;
      key = v[0].k;
      data = v[0].ct;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      in_valid = 1'b0;
      @(negedge clk);
      chk("reset_hs", {in_ready, out_valid}, 2'b10);
      chk("reset_st", r_out, 128'h0);

      // Known-answer table; C.1 twice exercises the cache hit path.
      for (int i = 0; i < 6; i++) run_vec(i);

      // Backpressure with ignored in_valid pulses.
      el = exp_lat(v[0].k);
      accept(v[0].k, v[0].ct, 1'b0, acc, ok);
      if (ok) begin
         wait_out(c, ok);
         if (ok) begin
            chk("bp_lat", c - acc, el);
            m_valid = 1'b1;
            m_key = v[0].k;
            for (int i = 0; i < 15; i++) begin
               in_valid = i[0];
               key = v[2].k;
               data = {4{$urandom}};
               @(negedge clk);
               chk($sformatf("bp_hold_%0d", i),
                   {out_valid, in_ready, r_out}, {2'b10, v[0].pt});
            end
            in_valid = 1'b0;
            out_ready = 1'b1;
            @(posedge clk);
            #1;
            out_ready = 1'b0;
            @(negedge clk);
            chk("bp_release", {in_ready, out_valid}, 2'b10);
            repeat (3) @(negedge clk);
            chk("bp_no_ghost", {in_ready, out_valid}, 2'b10);
         end
      end

      // Reset during the 5th ROUND cycle.
      el = exp_lat(v[0].k);
      accept(v[0].k, v[0].ct, 1'b0, acc, ok);
      if (ok) begin
         repeat (el - 6) @(posedge clk);
         @(negedge clk);
         reset = 1'b1;
         @(posedge clk);
         #1;
         reset = 1'b0;
         m_valid = 1'b0;
         @(negedge clk);
         chk("abort_hs", {in_ready, out_valid}, 2'b10);
         seen = 1'b0;
         for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
         end
         chk("abort_no_out", seen, 1'b0);
         run_vec(0);
      end

      // Streaming: in_valid and out_ready held high, alternating keys.
      out_ready = 1'b1;
      prev_acc = 0;
      prev_lat = 0;
      for (int b = 0; b < 4; b++) begin
         int j;
         j = (b % 2 == 0) ? 0 : 2;
         el = exp_lat(v[j].k);
         accept(v[j].k, v[j].ct, 1'b1, acc, ok);
         if (!ok) break;
         if (b > 0) chk($sformatf("str_gap_%0d", b), acc - prev_acc,
                        prev_lat + 2);
         key = v[3].k;
         data = v[3].ct;
         wait_out(c, ok);
         if (!ok) break;
         chk($sformatf("str_pt_%0d", b), r_out, v[j].pt);
         chk($sformatf("str_lat_%0d", b), c - acc, el);
         m_valid = 1'b1;
         m_key = v[j].k;
         prev_acc = acc;
         prev_lat = el;
      end
      in_valid = 1'b0;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      @(negedge clk);
      chk("str_end", {in_ready, out_valid}, 2'b10);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
